// File: rtl/id_ex_stage_pkg.sv
// Shared definitions for the ID/EX pipeline register: default widths,
// control-bundle bit positions and ALU operation encodings.
package id_ex_stage_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_ADDR_W = 5;
    localparam int CTRL_W     = 8;
    localparam int IMM_W      = 16;

    localparam int CTRL_REG_WRITE = 0;
    localparam int CTRL_MEM_READ  = 1;
    localparam int CTRL_MEM_WRITE = 2;
    localparam int CTRL_ALU_SRC   = 3;
    localparam int CTRL_REG_DST   = 4;
    localparam int CTRL_ZERO_EXT  = 5;
    localparam int CTRL_ALU_OP_LO = 6;
    localparam int CTRL_ALU_OP_HI = 7;

    typedef enum logic [1:0] {
        ALU_ADD   = 2'b00,
        ALU_SUB   = 2'b01,
        ALU_RTYPE = 2'b10,
        ALU_LOGIC = 2'b11
    } alu_op_e;

endpackage

// File: rtl/id_ex_stage_fwd_mux.sv
// Operand bypass selector: register 0 reads as zero, the younger EX/MEM
// result wins over the writeback bus, otherwise the register-bank data.
module fwd_mux #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic [ADDR_W-1:0] i_src_addr,
    input  logic [DATA_W-1:0] i_rf_data,
    input  logic              i_exm_we,
    input  logic [ADDR_W-1:0] i_exm_addr,
    input  logic [DATA_W-1:0] i_exm_data,
    input  logic              i_wb_we,
    input  logic [ADDR_W-1:0] i_wb_addr,
    input  logic [DATA_W-1:0] i_wb_data,
    output logic [DATA_W-1:0] o_data
);

    always_comb begin
        o_data = i_rf_data;
        if (i_src_addr == '0)
            o_data = '0;
        else if (i_exm_we && (i_exm_addr == i_src_addr))
            o_data = i_exm_data;
        else if (i_wb_we && (i_wb_addr == i_src_addr))
            o_data = i_wb_data;
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with operand bypass, flush/stall handling and a
// saturating bubble counter. Define ID_EX_FWD_EN to enable exm/wb bypassing.
module id_ex_stage
    import id_ex_stage_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              id_valid,
    input  logic [DATA_W-1:0] id_pc,
    input  logic [ADDR_W-1:0] id_rs,
    input  logic [ADDR_W-1:0] id_rt,
    input  logic [ADDR_W-1:0] id_rd,
    input  logic [IMM_W-1:0]  id_imm,
    input  logic [CTRL_W-1:0] id_ctrl,
    input  logic [DATA_W-1:0] rf_data_a,
    input  logic [DATA_W-1:0] rf_data_b,
    input  logic              wb_we,
    input  logic [ADDR_W-1:0] wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    input  logic              exm_we,
    input  logic [ADDR_W-1:0] exm_addr,
    input  logic [DATA_W-1:0] exm_data,
    input  logic              stall,
    input  logic              flush,
    output logic              ex_valid,
    output logic [DATA_W-1:0] ex_pc,
    output logic [DATA_W-1:0] ex_op_a,
    output logic [DATA_W-1:0] ex_op_b,
    output logic [DATA_W-1:0] ex_imm,
    output logic [ADDR_W-1:0] ex_dest,
    output logic [ADDR_W-1:0] ex_rs,
    output logic [ADDR_W-1:0] ex_rt,
    output logic [CTRL_W-1:0] ex_ctrl,
    output logic [15:0]       bubble_cnt
);

    logic              w_exm_we;
    logic              w_wb_we;
    logic [DATA_W-1:0] w_op_a;
    logic [DATA_W-1:0] w_op_b;
    logic [DATA_W-1:0] w_imm;
    logic [ADDR_W-1:0] w_dest;
    logic [15:0]       w_bubble_next;
    logic              w_refresh_a;
    logic              w_refresh_b;

    logic              r_valid;
    logic [DATA_W-1:0] r_pc;
    logic [DATA_W-1:0] r_op_a;
    logic [DATA_W-1:0] r_op_b;
    logic [DATA_W-1:0] r_imm;
    logic [ADDR_W-1:0] r_dest;
    logic [ADDR_W-1:0] r_rs;
    logic [ADDR_W-1:0] r_rt;
    logic [CTRL_W-1:0] r_ctrl;
    logic [15:0]       r_bubble_cnt;

    // Without bypassing the write enables are tied off, which also disables hold-refresh.
`ifdef ID_EX_FWD_EN
    assign w_exm_we = exm_we;
    assign w_wb_we  = wb_we;
`else
    logic w_unused_we;
    assign w_exm_we    = 1'b0;
    assign w_wb_we     = 1'b0;
    assign w_unused_we = exm_we ^ wb_we;
`endif

    fwd_mux #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_fwd_a (
        .i_src_addr (id_rs),
        .i_rf_data  (rf_data_a),
        .i_exm_we   (w_exm_we),
        .i_exm_addr (exm_addr),
        .i_exm_data (exm_data),
        .i_wb_we    (w_wb_we),
        .i_wb_addr  (wb_addr),
        .i_wb_data  (wb_data),
        .o_data     (w_op_a)
    );

    fwd_mux #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_fwd_b (
        .i_src_addr (id_rt),
        .i_rf_data  (rf_data_b),
        .i_exm_we   (w_exm_we),
        .i_exm_addr (exm_addr),
        .i_exm_data (exm_data),
        .i_wb_we    (w_wb_we),
        .i_wb_addr  (wb_addr),
        .i_wb_data  (wb_data),
        .o_data     (w_op_b)
    );

    assign w_imm = id_ctrl[CTRL_ZERO_EXT] ? {{(DATA_W-IMM_W){1'b0}}, id_imm}
                                          : {{(DATA_W-IMM_W){id_imm[IMM_W-1]}}, id_imm};
    assign w_dest = id_ctrl[CTRL_REG_WRITE] ? (id_ctrl[CTRL_REG_DST] ? id_rd : id_rt) : '0;
    assign w_bubble_next = (r_bubble_cnt == 16'hFFFF) ? r_bubble_cnt : r_bubble_cnt + 16'd1;

    // A held instruction must not miss a result retiring while it waits.
    assign w_refresh_a = w_wb_we && (r_rs != '0) && (wb_addr == r_rs);
    assign w_refresh_b = w_wb_we && (r_rt != '0) && (wb_addr == r_rt);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid      <= 1'b0;
            r_pc         <= '0;
            r_op_a       <= '0;
            r_op_b       <= '0;
            r_imm        <= '0;
            r_dest       <= '0;
            r_rs         <= '0;
            r_rt         <= '0;
            r_ctrl       <= '0;
            r_bubble_cnt <= '0;
        end else if (flush) begin
            r_valid      <= 1'b0;
            r_ctrl       <= '0;
            r_dest       <= '0;
            r_bubble_cnt <= w_bubble_next;
        end else if (stall) begin
            if (w_refresh_a)
                r_op_a <= wb_data;
            if (w_refresh_b)
                r_op_b <= wb_data;
        end else begin
            r_valid <= id_valid;
            r_pc    <= id_pc;
            r_op_a  <= w_op_a;
            r_op_b  <= w_op_b;
            r_imm   <= w_imm;
            r_dest  <= w_dest;
            r_rs    <= id_rs;
            r_rt    <= id_rt;
            r_ctrl  <= id_valid ? id_ctrl : '0;
            if (!id_valid)
                r_bubble_cnt <= w_bubble_next;
        end
    end

    assign ex_valid   = r_valid;
    assign ex_pc      = r_pc;
    assign ex_op_a    = r_op_a;
    assign ex_op_b    = r_op_b;
    assign ex_imm     = r_imm;
    assign ex_dest    = r_dest;
    assign ex_rs      = r_rs;
    assign ex_rt      = r_rt;
    assign ex_ctrl    = r_ctrl;
    assign bubble_cnt = r_bubble_cnt;

endmodule

// File: tb/tb_id_ex_stage.sv
// Randomized bench for id_ex_stage against a behavioural model of the stage;
// follows ID_EX_FWD_EN the same way the design does.
module tb_id_ex_stage;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
`ifdef ID_EX_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              reset, id_valid, wb_we, exm_we, stall, flush;
    logic [DATA_W-1:0] id_pc, rf_data_a, rf_data_b, wb_data, exm_data;
    logic [ADDR_W-1:0] id_rs, id_rt, id_rd, wb_addr, exm_addr;
    logic [15:0]       id_imm;
    logic [7:0]        id_ctrl;
    logic              ex_valid;
    logic [DATA_W-1:0] ex_pc, ex_op_a, ex_op_b, ex_imm;
    logic [ADDR_W-1:0] ex_dest, ex_rs, ex_rt;
    logic [7:0]        ex_ctrl;
    logic [15:0]       bubble_cnt;

    logic              mValid;
    logic [DATA_W-1:0] mPc, mOpA, mOpB, mImm;
    logic [ADDR_W-1:0] mDest, mRs, mRt;
    logic [7:0]        mCtrl;
    logic [15:0]       mBub;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    id_ex_stage #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_pc(id_pc),
        .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .id_imm(id_imm),
        .id_ctrl(id_ctrl), .rf_data_a(rf_data_a), .rf_data_b(rf_data_b),
        .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
        .exm_we(exm_we), .exm_addr(exm_addr), .exm_data(exm_data),
        .stall(stall), .flush(flush), .ex_valid(ex_valid), .ex_pc(ex_pc),
        .ex_op_a(ex_op_a), .ex_op_b(ex_op_b), .ex_imm(ex_imm),
        .ex_dest(ex_dest), .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_ctrl(ex_ctrl),
        .bubble_cnt(bubble_cnt)
    );

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference: the newest producer of a register wins; register 0 is always zero.
    function automatic logic [DATA_W-1:0] operand(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] rf);
        if (a == 0) return 0;
        if (FWD && exm_we && exm_addr == a) return exm_data;
        if (FWD && wb_we && wb_addr == a) return wb_data;
        return rf;
    endfunction

    task automatic modelEdge();
        if (reset) begin
            mValid = 0; mPc = 0; mOpA = 0; mOpB = 0; mImm = 0;
            mDest = 0; mRs = 0; mRt = 0; mCtrl = 0; mBub = 0;
        end else if (flush) begin
            mValid = 0; mCtrl = 0; mDest = 0;
            if (mBub != 16'hFFFF) mBub = mBub + 1;
        end else if (stall) begin
            if (FWD && wb_we && mRs != 0 && wb_addr == mRs) mOpA = wb_data;
            if (FWD && wb_we && mRt != 0 && wb_addr == mRt) mOpB = wb_data;
        end else begin
            mValid = id_valid;
            mPc    = id_pc;
            mOpA   = operand(id_rs, rf_data_a);
            mOpB   = operand(id_rt, rf_data_b);
            mImm   = id_ctrl[5] ? {16'h0000, id_imm} : (id_imm[15] ? {16'hFFFF, id_imm} : {16'h0000, id_imm});
            mRs    = id_rs;
            mRt    = id_rt;
            mCtrl  = id_valid ? id_ctrl : 8'h00;
            mDest  = !id_ctrl[0] ? 5'd0 : (id_ctrl[4] ? id_rd : id_rt);
            if (!id_valid && mBub != 16'hFFFF) mBub = mBub + 1;
        end
    endtask

    task automatic checkAll(input string tag);
        checkOutput({tag, ".valid"}, 32'(ex_valid), 32'(mValid));
        checkOutput({tag, ".pc"},    ex_pc,   mPc);
        checkOutput({tag, ".opa"},   ex_op_a, mOpA);
        checkOutput({tag, ".opb"},   ex_op_b, mOpB);
        checkOutput({tag, ".imm"},   ex_imm,  mImm);
        checkOutput({tag, ".dest"},  32'(ex_dest), 32'(mDest));
        checkOutput({tag, ".rs"},    32'(ex_rs),   32'(mRs));
        checkOutput({tag, ".rt"},    32'(ex_rt),   32'(mRt));
        checkOutput({tag, ".ctrl"},  32'(ex_ctrl), 32'(mCtrl));
        checkOutput({tag, ".bub"},   32'(bubble_cnt), 32'(mBub));
    endtask

    task automatic stepClock(input string tag, input bit doCheck);
        @(posedge clk);
        modelEdge();
        #1;
        if (doCheck) checkAll(tag);
    endtask

    task automatic setIdle();
        reset = 0; id_valid = 0; id_pc = 0; id_rs = 0; id_rt = 0; id_rd = 0;
        id_imm = 0; id_ctrl = 0; rf_data_a = 0; rf_data_b = 0;
        wb_we = 0; wb_addr = 0; wb_data = 0; exm_we = 0; exm_addr = 0; exm_data = 0;
        stall = 0; flush = 0;
    endtask

    task automatic applyStimulus();
        reset     = ($urandom_range(0, 39) == 0);
        flush     = ($urandom_range(0, 7) == 0);
        stall     = ($urandom_range(0, 4) == 0);
        id_valid  = ($urandom_range(0, 3) != 0);
        id_pc     = $urandom;
        id_rs     = 5'($urandom_range(0, 7));
        id_rt     = 5'($urandom_range(0, 7));
        id_rd     = 5'($urandom_range(0, 31));
        id_imm    = 16'($urandom);
        id_ctrl   = 8'($urandom);
        rf_data_a = $urandom;
        rf_data_b = $urandom;
        wb_we     = 1'($urandom);
        wb_addr   = 5'($urandom_range(0, 7));
        wb_data   = $urandom;
        exm_we    = 1'($urandom);
        exm_addr  = 5'($urandom_range(0, 7));
        exm_data  = $urandom;
    endtask

    initial begin
        logic [15:0] bubBefore;
        setIdle();
        reset = 1;
        stepClock("reset0", 1);
        stepClock("reset1", 1);
        checkOutput("reset_bub", 32'(bubble_cnt), 32'h0);

        setIdle();
        id_valid = 1; id_rs = 3; rf_data_a = 32'h11; id_ctrl = 8'h01; id_rt = 4; id_rd = 6;
        stepClock("basic", 1);
        checkOutput("basic_opa", ex_op_a, 32'h11);
        checkOutput("basic_valid", 32'(ex_valid), 32'h1);

        exm_we = 1; exm_addr = 3; exm_data = 32'hAA; wb_we = 1; wb_addr = 3; wb_data = 32'hBB;
        stepClock("bypass", 1);
        checkOutput("bypass_opa", ex_op_a, FWD ? 32'hAA : 32'h11);

        setIdle();
        id_valid = 1; id_rt = 0; rf_data_b = 32'hDEAD; wb_we = 1; wb_addr = 0; wb_data = 32'h99;
        stepClock("r0", 1);
        checkOutput("r0_opb", ex_op_b, 32'h0);

        id_imm = 16'h8001; id_ctrl = 8'h00;
        stepClock("sext", 1);
        checkOutput("sext_imm", ex_imm, 32'hFFFF8001);
        id_ctrl = 8'h20;
        stepClock("zext", 1);
        checkOutput("zext_imm", ex_imm, 32'h00008001);

        setIdle();
        id_valid = 1; id_rs = 5; rf_data_a = 32'h77; id_pc = 32'h400; id_ctrl = 8'h11; id_rd = 9;
        stepClock("pre_stall", 1);
        setIdle();
        stall = 1; id_pc = 32'h999;
        stepClock("stall1", 1);
        wb_we = 1; wb_addr = 5; wb_data = 32'h55;
        stepClock("stall2", 1);
        wb_we = 0;
        stepClock("stall3", 1);
        checkOutput("stall_opa", ex_op_a, FWD ? 32'h55 : 32'h77);
        checkOutput("stall_pc", ex_pc, 32'h400);
        checkOutput("stall_dest", 32'(ex_dest), 32'd9);

        bubBefore = bubble_cnt;
        flush = 1; stall = 1;
        stepClock("flush_stall", 1);
        checkOutput("flush_valid", 32'(ex_valid), 32'h0);
        checkOutput("flush_bub", 32'(bubble_cnt), 32'(bubBefore) + 32'd1);

        for (int i = 0; i < 400; i++) begin
            applyStimulus();
            stepClock("rand", 1);
        end

        setIdle();
        flush = 1;
        for (int i = 0; i < 65540; i++) stepClock("sat", 0);
        checkAll("sat");
        checkOutput("sat_bub", 32'(bubble_cnt), 32'hFFFF);

        reset = 1; stall = 1; flush = 1;
        stepClock("reset_mid", 1);
        checkOutput("reset_mid_bub", 32'(bubble_cnt), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 Parameter DATA_W, default 32, datapath width.
REQ-002 Parameter ADDR_W, default 5, register address width.
REQ-003 clk  in  1  single clock; all state updates on its rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 id_valid  in  1  decode slot holds a real instruction.
REQ-006 id_pc  in  DATA_W  PC of decoded instruction.
REQ-007 id_rs, id_rt, id_rd  in  ADDR_W each  source/destination register numbers.
REQ-008 id_imm  in  16  raw immediate.
REQ-009 id_ctrl  in  8  control bundle: [0] reg_write, [1] mem_read, [2] mem_write, [3] alu_src, [4] reg_dst, [5] zero_ext, [7:6] alu_op.
REQ-010 rf_data_a, rf_data_b  in  DATA_W  register-bank read data for id_rs/id_rt.
REQ-011 wb_we, wb_addr, wb_data  in  1/ADDR_W/DATA_W  writeback bus (same bus driving the register bank write port).
REQ-012 exm_we, exm_addr, exm_data  in  1/ADDR_W/DATA_W  EX/MEM result bus.
REQ-013 stall  in  1  hold this stage; flush  in  1  kill this stage.
REQ-014 ex_valid, ex_pc, ex_op_a, ex_op_b, ex_imm (DATA_W), ex_dest, ex_rs, ex_rt (ADDR_W), ex_ctrl (8)  out  registered EX-stage bundle.
REQ-015 bubble_cnt  out  16  saturating count of bubbles issued.

Function
REQ-016 Priority each edge: reset > flush > stall > capture.
REQ-017 Capture: all ex_* outputs load from ID inputs; latency exactly one cycle.
REQ-018 Operand select per source: addr==0 -> 0; else exm_we && exm_addr match -> exm_data; else wb_we && wb_addr match -> wb_data; else rf data.
REQ-019 ex_imm = zero_ext ? {16'b0,id_imm} : sign-extended id_imm.
REQ-020 ex_dest = reg_dst ? id_rd : id_rt; forced to 0 when reg_write=0.
REQ-021 id_valid=0 on capture: ex_valid=0, ex_ctrl=0 (bubble); other fields don't-care but deterministic (loaded normally).
REQ-022 Flush: ex_valid=0, ex_ctrl=0, ex_dest=0; data fields hold; flush overrides simultaneous stall.
REQ-023 Stall: all fields hold, except hold-refresh: if wb_we and wb_addr==ex_rs (nonzero) ex_op_a<=wb_data; same for ex_rt/ex_op_b.
REQ-024 bubble_cnt increments by 1 on each edge that loads ex_valid=0 via flush or id_valid=0; saturates at 16'hFFFF; no change on stall.

Reset
REQ-025 On reset every output, including bubble_cnt, is 0 on the next edge; reset mid-stall or mid-flush discards held state.
REQ-026 No output is undefined after the first reset edge.

Configuration
REQ-027 Macro ID_EX_FWD_EN: defined -> REQ-018 exm/wb selection and REQ-023 hold-refresh active.
REQ-028 Not defined -> operands are rf data (register 0 still forced to 0), no hold-refresh; exm_*/wb_* ignored.

Structure
REQ-029 Shared package holds DATA_W/ADDR_W defaults, id_ctrl bit-index constants and alu_op encodings.
REQ-030 One sub-module, fwd_mux, implements the REQ-018 selection; instantiated twice (A and B).

Verification
REQ-031 id_rs=3, rf_data_a=0x11, no bypass, capture -> next cycle ex_op_a=0x11, ex_valid=1.
REQ-032 id_rs=3, exm_we=1 exm_addr=3 exm_data=0xAA, wb_we=1 wb_addr=3 wb_data=0xBB -> ex_op_a=0xAA (FWD_EN); 0x11 without macro.
REQ-033 id_rt=0, rf_data_b=0xDEAD, wb_we=1 wb_addr=0 -> ex_op_b=0.
REQ-034 id_imm=0x8001, zero_ext=0 -> ex_imm=0xFFFF8001; zero_ext=1 -> 0x00008001.
REQ-035 Stall 3 cycles with ex_rs=5, wb_we=1 wb_addr=5 wb_data=0x55 in cycle 2 -> ex_op_a=0x55 after, other fields unchanged.
REQ-036 flush and stall together -> ex_valid=0, bubble_cnt+1; 65536 bubbles -> bubble_cnt stays 0xFFFF; reset -> all 0.
